// File: rtl/z_core_alu_arbiter.sv
// z_core_alu_arbiter: shares one combinational ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP. Operands are latched on accept,
// the ALU result is captured after one EXEC cycle and held for the owner
// until it is taken.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration on a tie;
// without it req0 has fixed priority and no last-grant state exists.
module z_core_alu_arbiter #(
    parameter logic [3:0] IDLE_OP = 4'd0,
    parameter int         DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic [3:0]        req0_op,
    input  logic [3:0]        req1_op,
    output logic              resp0_valid,
    output logic              resp1_valid,
    input  logic              resp0_ready,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp0_branch,
    output logic              resp1_branch,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_inst_type,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_branch,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    logic   owner;      // 0: req0 owns the in-flight op, 1: req1
    logic   grant;      // requester that would be accepted this cycle
    logic   in_idle;
    logic   accept;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    // Round-robin: on a tie, favour the requester not served last
    always_comb begin
        grant = ~req0_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
    end

    // Remember who was served on every accept; requester 1 after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`else
    // Fixed priority: req0 wins whenever it is valid
    always_comb begin
        grant = ~req0_valid;
    end
`endif

    // Ready only in IDLE and never while reset is held
    assign in_idle    = (state == S_IDLE) && rstn;
    assign req0_ready = in_idle && req0_valid && !grant;
    assign req1_ready = in_idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != S_IDLE);

    // Transaction FSM: latch operands, capture ALU result, hold response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            owner         <= 1'b0;
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_inst_type <= IDLE_OP;
            resp0_valid   <= 1'b0;
            resp1_valid   <= 1'b0;
            resp0_result  <= '0;
            resp1_result  <= '0;
            resp0_branch  <= 1'b0;
            resp1_branch  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner         <= grant;
                        alu_in1       <= grant ? req1_in1 : req0_in1;
                        alu_in2       <= grant ? req1_in2 : req0_in2;
                        alu_inst_type <= grant ? req1_op  : req0_op;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (owner) begin
                        resp1_result <= alu_out;
                        resp1_branch <= alu_branch;
                        resp1_valid  <= 1'b1;
                    end else begin
                        resp0_result <= alu_out;
                        resp0_branch <= alu_branch;
                        resp0_valid  <= 1'b1;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (owner ? resp1_ready : resp0_ready) begin
                        resp0_valid   <= 1'b0;
                        resp1_valid   <= 1'b0;
                        alu_inst_type <= IDLE_OP;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z_core_alu_arbiter.sv
// Testbench for z_core_alu_arbiter with a behavioural ALU on the shared port
// and a scoreboard of expected responses.
module tb_z_core_alu_arbiter;

    logic        clk;
    logic        rstn;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]  req0_op, req1_op;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_branch, resp1_branch;
    logic [31:0] alu_in1, alu_in2;
    logic [3:0]  alu_inst_type;
    logic [31:0] alu_out;
    logic        alu_branch;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          port;
        logic [31:0] res;
        logic        br;
    } exp_t;
    exp_t exp_q[$];

    z_core_alu_arbiter #(.IDLE_OP(4'd0)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .req0_op(req0_op), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp0_result(resp0_result), .resp1_result(resp1_result),
        .resp0_branch(resp0_branch), .resp1_branch(resp1_branch),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_inst_type(alu_inst_type),
        .alu_out(alu_out), .alu_branch(alu_branch),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU: branch flag set when the result is zero
    always_comb begin
        alu_out    = alu_f(alu_inst_type, alu_in1, alu_in2);
        alu_branch = (alu_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction
    function automatic logic rv(input int p);
        return (p == 0) ? resp0_valid : resp1_valid;
    endfunction
    function automatic logic [31:0] rres(input int p);
        return (p == 0) ? resp0_result : resp1_result;
    endfunction
    function automatic logic rbr(input int p);
        return (p == 0) ? resp0_branch : resp1_branch;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (p == 0) begin
            req0_valid = v; req0_in1 = a; req0_in2 = b; req0_op = op;
        end else begin
            req1_valid = v; req1_in1 = a; req1_in2 = b; req1_op = op;
        end
    endtask

    task automatic set_rr(input int p, input logic v);
        if (p == 0) resp0_ready = v;
        else        resp1_ready = v;
    endtask

    task automatic set_other_valid(input int p, input logic v);
        if (p == 0) req1_valid = v;
        else        req0_valid = v;
    endtask

    task automatic check_pop(input int p, input string tag);
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_unexpected observed=resp%0d expected=none", tag, p);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_port"}, p, e.port);
            chk({tag, "_res"}, rres(p), e.res);
            chk({tag, "_br"}, {31'd0, rbr(p)}, {31'd0, e.br});
        end
    endtask

    // One complete transaction on port p with hold cycles of response backpressure
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input int hold, input string tag);
        exp_t e;
        e.port = p;
        e.res  = alu_f(op, a, b);
        e.br   = (e.res == 32'd0);
        @(negedge clk);
        set_req(p, 1'b1, a, b, op);
        set_rr(p, 1'b0);
        #1 chk({tag, "_acc_ready"}, {31'd0, rdy(p)}, 32'd1);
        exp_q.push_back(e);
        @(negedge clk);
        set_req(p, 1'b0, 32'd0, 32'hFFFF_FFFF, 4'hF);
        #1;
        chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_alu_in1"}, alu_in1, a);
        chk({tag, "_alu_in2"}, alu_in2, b);
        chk({tag, "_alu_op"}, {28'd0, alu_inst_type}, {28'd0, op});
        chk({tag, "_exec_nvalid"}, {31'd0, rv(p)}, 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_lat_valid"}, {31'd0, rv(p)}, 32'd1);
        chk({tag, "_other_nvalid"}, {31'd0, rv(1 - p)}, 32'd0);
        if (hold > 0) set_other_valid(p, 1'b1);
        for (int k = 0; k < hold; k++) begin
            #1;
            chk({tag, "_bp_other_ready"}, {31'd0, rdy(1 - p)}, 32'd0);
            chk({tag, "_bp_valid"}, {31'd0, rv(p)}, 32'd1);
            chk({tag, "_bp_res"}, rres(p), e.res);
            chk({tag, "_bp_busy"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            #1;
        end
        set_other_valid(p, 1'b0);
        set_rr(p, 1'b1);
        chk({tag, "_take_valid"}, {31'd0, rv(p)}, 32'd1);
        check_pop(p, tag);
        chk({tag, "_take_other_nvalid"}, {31'd0, rv(1 - p)}, 32'd0);
        @(negedge clk);
        set_rr(p, 1'b0);
        #1;
        chk({tag, "_done_nvalid"}, {31'd0, rv(p)}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_idle_op"}, {28'd0, alu_inst_type}, 32'd0);
        chk({tag, "_done_in1_hold"}, alu_in1, a);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int grants;
        int expg[5];
        int g;
        rstn = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_in1 = 32'd1; req0_in2 = 32'd1; req0_op = 4'd0;
        req1_in1 = 32'd1; req1_in2 = 32'd1; req1_op = 4'd0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;

        // Reset state with both requesters asserting valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res0", resp0_result, 32'd0);
        chk("rst_res1", resp1_result, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_in2", alu_in2, 32'd0);
        chk("rst_alu_op", {28'd0, alu_inst_type}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Single ADD, backpressured SUB, zero-result branch, operand change after accept
        do_op(0, 32'd2, 32'd3, 4'd0, 0, "add");
        do_op(1, 32'd5, 32'd3, 4'd1, 4, "sub_bp");
        do_op(1, 32'd7, 32'd7, 4'd1, 1, "sub_zero");
        do_op(0, 32'd12, 32'd2, 4'd6, 0, "srl");

        // Reset during EXEC discards the transaction
        @(negedge clk);
        set_req(0, 1'b1, 32'd9, 32'd9, 4'd0);
        set_rr(0, 1'b1);
        #1 chk("mid_acc_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1 chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_alu_in1", alu_in1, 32'd0);
        chk("mid_rst_alu_op", {28'd0, alu_inst_type}, 32'd0);
        chk("mid_rst_res0", resp0_result, 32'd0);
        chk("mid_rst_res1", resp1_result, 32'd0);
        chk("mid_rst_valid0", {31'd0, resp0_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_nvalid0", {31'd0, resp0_valid}, 32'd0);
            chk("post_rst_nvalid1", {31'd0, resp1_valid}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        set_rr(0, 1'b0);
        do_op(0, 32'd2, 32'd8, 4'd2, 0, "sll");

        // Tie: both requesters valid continuously, then req0 drops after four grants
        reset_pulse();
`ifdef ALU_ARB_RR_EN
        expg = '{0, 1, 0, 1, 1};
`else
        expg = '{0, 0, 0, 0, 1};
`endif
        grants = 0;
        @(negedge clk);
        set_req(0, 1'b1, 32'd2, 32'd1, 4'd2);
        set_req(1, 1'b1, 32'd12, 32'd5, 4'd5);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int c = 0; c < 80 && !(grants == 5 && exp_q.size() == 0); c++) begin
            if (c > 0) @(negedge clk);
            if (grants >= 4) req0_valid = 1'b0;
            if (grants >= 5) req1_valid = 1'b0;
            #1;
            if (resp0_valid) check_pop(0, "tie_r0");
            if (resp1_valid) check_pop(1, "tie_r1");
            if (req0_ready || req1_ready) begin
                exp_t e;
                g = req1_ready ? 1 : 0;
                chk("tie_one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
                if (grants < 5) chk("tie_grant", g, expg[grants]);
                e.port = g;
                e.res  = (g == 0) ? 32'd4 : 32'd9;
                e.br   = 1'b0;
                exp_q.push_back(e);
                grants++;
            end
        end
        chk("tie_grant_count", grants, 32'd5);
        chk("tie_queue_empty", exp_q.size(), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z_core_alu_arbiter.md
Z_CORE_ALU_ARBITER -- requirements
Module: z_core_alu_arbiter

Interface
REQ-001 SHALL have parameter IDLE_OP, default 4'd0: alu_inst_type value driven when no transaction is in flight.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester n presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1 each  operation accepted this cycle.
REQ-006 SHALL have ports req0_in1/req0_in2/req1_in1/req1_in2  input  32 each  operands.
REQ-007 SHALL have ports req0_op/req1_op  input  4 each  ALU instruction type, passed unmodified.
REQ-008 SHALL have ports resp0_valid/resp1_valid  output  1 each  result available to requester n.
REQ-009 SHALL have ports resp0_ready/resp1_ready  input  1 each  requester n takes the result.
REQ-010 SHALL have ports resp0_result/resp1_result  output  32 each, and resp0_branch/resp1_branch  output  1 each  registered ALU outputs.
REQ-011 SHALL have ports alu_in1/alu_in2  output  32 each and alu_inst_type  output  4  drive the shared ALU.
REQ-012 SHALL have ports alu_out  input  32 and alu_branch  input  1  from the shared combinational ALU.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-015 In IDLE, SHALL assert reqN_ready combinationally only for the granted requester, and only when its reqN_valid is high.
REQ-016 On the accept edge (valid && ready), SHALL register in1, in2 and op onto alu_in1/alu_in2/alu_inst_type, record the grant owner and enter EXEC.
REQ-017 In EXEC (exactly one cycle), SHALL capture alu_out/alu_branch into the owner's respN_result/respN_branch and enter RESP.
REQ-018 In RESP, SHALL hold respN_valid high for the owner only, with result stable, until respN_ready is high; then SHALL deassert it and return to IDLE.
REQ-019 Accept-to-respN_valid latency SHALL be 2 cycles; peak throughput SHALL be one operation per 3 cycles.
REQ-020 SHALL not accept a new request in EXEC or RESP; both reqN_ready SHALL be 0 there.
REQ-021 On return to IDLE, SHALL drive alu_inst_type to IDLE_OP, with alu_in1/alu_in2 holding their last values.
REQ-022 The non-owner's resp outputs SHALL remain 0 valid, and their result/branch values unchanged, throughout a transaction.
REQ-023 Changes on reqN inputs after acceptance SHALL not affect the in-flight result.

Reset
REQ-024 While rstn is low: state IDLE, all ready/valid/busy outputs 0, results/branches 0, alu_in1/alu_in2 0, alu_inst_type IDLE_OP, last-grant = requester 1.
REQ-025 Reset asserted mid-transaction SHALL discard it silently; no response SHALL be issued after release.

Configuration
REQ-026 With ALU_ARB_RR_EN defined, SHALL arbitrate round-robin: when both are valid in IDLE, SHALL grant the requester not served last; last-grant SHALL update on each accept.
REQ-027 Without ALU_ARB_RR_EN, SHALL use fixed priority: req0 always wins a tie; last-grant register SHALL be absent.
REQ-028 A single valid requester SHALL always be granted in either configuration.

Verification
REQ-029 Single op: req0 ADD 2,3 (op 0), resp0_ready=1 -> resp0_valid 2 cycles after accept, resp0_result=5; resp1_valid stays 0.
REQ-030 Backpressure: req1 SUB 5,3 (op 1), resp1_ready low 4 cycles -> resp1_valid held, result=2 stable, busy=1, req0_ready=0 throughout.
REQ-031 Tie with ALU_ARB_RR_EN, both valid continuously -> grants alternate 0,1,0,1; results 2<<1=4 (op 2) and 12^5=9 (op 5) routed to the correct ports.
REQ-032 Tie without ALU_ARB_RR_EN, both valid continuously -> req0 served every transaction; req1 starves until req0_valid drops.
REQ-033 rstn pulsed low during EXEC -> all outputs at reset values immediately; no resp valid after release; next req0 SLL 2,8 (op 2) returns 512.
REQ-034 Operand change after accept: req0 SRL 12,2 (op 6) accepted, then req0_in1 changed to 0 -> resp0_result=3.
